ahb_logic_initiator: RTL

//  AHB-Lite master in FPGA logic driving the slave_ahb_* port of alta_rv32, so logic can read/write SoC memory.
//  It is the initiator counterpart of the logic-side mem_ahb responder.
//  A command (address, beat count, direction) becomes one or more INCR bursts of 32-bit words.

---
 rtl/ahb_logic_initiator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ahb_logic_initiator.sv
// AHB-Lite initiator: turns (addr, len, dir) commands into INCR bursts of 32-bit words.
// Optional wait-state watchdog is compiled in with `define AHB_INIT_TIMEOUT_EN.
module ahb_logic_initiator #(
  parameter int MAX_BEATS   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       sys_clock,
  input  logic                       sys_reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [31:0]                cmd_addr,
  input  logic [$clog2(MAX_BEATS):0] cmd_len,
  input  logic [31:0]                wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic                       done,
  output logic                       err,
  output logic                       slave_ahb_hsel,
  output logic                       slave_ahb_hready,
  output logic [1:0]                 slave_ahb_htrans,
  output logic [2:0]                 slave_ahb_hsize,
  output logic [2:0]                 slave_ahb_hburst,
  output logic                       slave_ahb_hwrite,
  output logic [31:0]                slave_ahb_haddr,
  output logic [31:0]                slave_ahb_hwdata,
  input  logic                       slave_ahb_hreadyout,
  input  logic                       slave_ahb_hresp,
  input  logic [31:0]                slave_ahb_hrdata
);
  localparam int LW = $clog2(MAX_BEATS) + 1;
  localparam logic [1:0] TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_DONE} state_t;

  typedef struct packed {
    logic          write;
    logic [31:0]   addr;
    logic [LW-1:0] left;   // beats whose address phase is still to be accepted
    logic          first;
  } burst_t;

  state_t        state, state_nxt;
  burst_t        cur;
  logic          hold_full, dp_valid, dp_write, err_q;
  logic [31:0]   hold_q, hwdata_q, beat_data;
  logic [LW-1:0] len_eff;
  logic [1:0]    trans;
  logic          issuing, have_data, wr_fire, addr_go, dp_done, err_first, timeout;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0)                 len_eff = LW'(1);
    else if (cmd_len > LW'(MAX_BEATS)) len_eff = LW'(MAX_BEATS);
  end

  assign issuing   = (state == S_ADDR);
  assign wr_ready  = issuing & cur.write & ~hold_full;
  assign wr_fire   = wr_valid & wr_ready;
  // a beat arriving this cycle can go straight onto the bus, so streams run gap-free
  assign have_data = ~cur.write | hold_full | wr_valid;
  assign beat_data = hold_full ? hold_q : wr_data;
  assign addr_go   = slave_ahb_hreadyout & trans[1];
  assign dp_done   = dp_valid & slave_ahb_hreadyout;
  assign err_first = dp_valid & slave_ahb_hresp & ~slave_ahb_hreadyout;

`ifdef AHB_INIT_TIMEOUT_EN
  logic [31:0] wait_cnt;
  always_ff @(posedge sys_clock) begin
    if (sys_reset || !dp_valid || slave_ahb_hreadyout) wait_cnt <= '0;
    else                                               wait_cnt <= wait_cnt + 32'd1;
  end
  assign timeout = (state == S_ADDR || state == S_DATA) & dp_valid & ~slave_ahb_hreadyout &
                   ~slave_ahb_hresp & (wait_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    trans     = TR_IDLE;
    if (issuing) begin
      // 1 KB crossings restart the burst with NONSEQ
      if (have_data)      trans = (cur.first || cur.addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
      else if (!cur.first) trans = TR_BUSY;
    end
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = S_ADDR;
      S_ADDR: begin
        if (err_first)                           state_nxt = S_ERR2;
        else if (timeout)                        state_nxt = S_DONE;
        else if (addr_go && cur.left == LW'(1))  state_nxt = S_DATA;
      end
      S_DATA: begin
        if (err_first)    state_nxt = S_ERR2;
        else if (timeout) state_nxt = S_DONE;
        else if (dp_done) state_nxt = S_DONE;
      end
      S_ERR2: if (slave_ahb_hreadyout) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      hold_full <= 1'b0;
      hold_q    <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      hwdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd_valid) begin
        cur.write <= cmd_write;
        cur.addr  <= {cmd_addr[31:2], 2'b00};
        cur.left  <= len_eff;
        cur.first <= 1'b1;
        err_q     <= 1'b0;
        hold_full <= 1'b0;
      end
      if (wr_fire && !addr_go) begin
        hold_full <= 1'b1;
        hold_q    <= wr_data;
      end
      if (addr_go) begin
        hold_full <= 1'b0;
        cur.addr  <= cur.addr + 32'd4;
        cur.left  <= cur.left - LW'(1);
        cur.first <= 1'b0;
        dp_valid  <= 1'b1;
        dp_write  <= cur.write;
        if (cur.write) hwdata_q <= beat_data;
      end else if (slave_ahb_hreadyout) begin
        dp_valid <= 1'b0;
      end
      if (err_first || timeout) begin
        err_q     <= 1'b1;
        hold_full <= 1'b0;
        cur.left  <= '0;
      end
      // abandoned beat: a late hreadyout must not look like a completion
      if (timeout) dp_valid <= 1'b0;
    end
  end

  assign cmd_ready        = (state == S_IDLE);
  assign done             = (state == S_DONE);
  assign err              = done & err_q;
  assign rd_valid         = dp_valid & ~dp_write & slave_ahb_hreadyout & ~slave_ahb_hresp;
  assign rd_data          = rd_valid ? slave_ahb_hrdata : '0;
  assign slave_ahb_hsel   = (trans != TR_IDLE) | dp_valid;
  assign slave_ahb_hready = slave_ahb_hreadyout;
  assign slave_ahb_htrans = trans;
  assign slave_ahb_hsize  = 3'b010;
  assign slave_ahb_hburst = 3'b001;
  assign slave_ahb_hwrite = cur.write & (trans != TR_IDLE);
  assign slave_ahb_haddr  = issuing ? cur.addr : '0;
  assign slave_ahb_hwdata = hwdata_q;

endmodule
